// File: rtl/tra_pkg.sv
// Shared state codes for the intersection sequencer and the light driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tra_pkg;

    // Fixed 2-bit phase codes decoded by the light driver.
    localparam logic [1:0] ST_MG = 2'd0;  // main green,  country red
    localparam logic [1:0] ST_MY = 2'd1;  // main yellow, country red
    localparam logic [1:0] ST_CG = 2'd2;  // main red,    country green
    localparam logic [1:0] ST_CY = 2'd3;  // main red,    country yellow

    typedef enum logic [1:0] {
        S_MG = ST_MG,
        S_MY = ST_MY,
        S_CG = ST_CG,
        S_CY = ST_CY
    } tra_state_e;

endpackage

// File: rtl/tick_gen.sv
// 1-second tick prescaler: counts 0..TICK_DIV-1 and flags each wrap.
// Latency: tick is registered; first pulse TICK_DIV clk after reset release, then every TICK_DIV clk.
// Backpressure: none, free-running.
// Ports: clk (system clock), rst_n (async active-low reset), tick (one-clk pulse per period).
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // tick is raised in the cycle that follows the counter's wrap, so it
    // comes straight from a flop and carries no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tra_state_ctrl.sv
// Highway/country-road light sequencer: phase FSM plus remaining-seconds counter.
// Latency: state/remain change on the clk edge after a tick cycle; c_car reaches the FSM 2 clk after sampling.
// Backpressure: none, all decisions are gated only by the 1 s tick.
// Ports: clk, rst_n (async active-low), c_car (async car sensor level),
//        current_state (phase code, see tra_pkg), remain (seconds left), tick (1 s pulse).
module tra_state_ctrl
    import tra_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int M_GREEN_MIN = 30,
    parameter int M_YELLOW    = 3,
    parameter int C_GREEN_MAX = 20,
    parameter int C_YELLOW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       c_car,
    output logic [1:0] current_state,
    output logic [7:0] remain,
    output logic       tick
);

    localparam logic [7:0] DUR_MG = 8'(M_GREEN_MIN);
    localparam logic [7:0] DUR_MY = 8'(M_YELLOW);
    localparam logic [7:0] DUR_CG = 8'(C_GREEN_MAX);
    localparam logic [7:0] DUR_CY = 8'(C_YELLOW);

    tra_state_e state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic       car_meta, car_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous sensor level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_meta <= 1'b0;
            car_s    <= 1'b0;
        end else begin
            car_meta <= c_car;
            car_s    <= car_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_MG;
            remain_q <= DUR_MG;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Decrements only happen from values >= 2, so remain never underflows.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (tick) begin
            case (state_q)
                S_MG: begin
                    if (remain_q > 8'd1) begin
                        remain_d = remain_q - 8'd1;
                    end else if (car_s) begin
                        state_d  = S_MY;
                        remain_d = DUR_MY;
                    end else begin
                        // Minimum served and no car: park at 0, main stays green.
                        remain_d = 8'd0;
                    end
                end
                S_MY: begin
                    if (remain_q == 8'd1) begin
                        state_d  = S_CG;
                        remain_d = DUR_CG;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
                S_CG: begin
                    // Leave early once the country road empties, or at the cap.
                    if (remain_q == 8'd1 || !car_s) begin
                        state_d  = S_CY;
                        remain_d = DUR_CY;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
                S_CY: begin
                    if (remain_q == 8'd1) begin
                        state_d  = S_MG;
                        remain_d = DUR_MG;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
            endcase
        end
    end

    assign current_state = state_q;
    assign remain        = remain_q;

endmodule

// File: tb/tb_tra_state_ctrl.sv
// Self-checking bench for tra_state_ctrl: vector table, hand-written corner sequences, random sensor traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_tra_state_ctrl;

    localparam int D   = 4;
    localparam int MGD = 5;
    localparam int MYD = 2;
    localparam int CGD = 6;
    localparam int CYD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       c_car;
    logic [1:0] current_state;
    logic [7:0] remain;
    logic       tick;

    always #5 clk = ~clk;

    tra_state_ctrl #(
        .TICK_DIV    (D),
        .M_GREEN_MIN (MGD),
        .M_YELLOW    (MYD),
        .C_GREEN_MAX (CGD),
        .C_YELLOW    (CYD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .c_car         (c_car),
        .current_state (current_state),
        .remain        (remain),
        .tick          (tick)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase + seconds elapsed in that phase; remain is derived from the phase length.
    // m_n counts clock edges since reset release; c_car is seen by the sequencer 2 edges later.
    int   m_n, m_phase, m_el;
    logic m_d1, m_d2;
    bit   chk_on = 1'b0;

    function automatic int dur(input int p);
        case (p)
            0:       return MGD;
            1:       return MYD;
            2:       return CGD;
            default: return CYD;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_phase <= 0; m_el <= 0; m_d1 <= 1'b0; m_d2 <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            // A second ends on every D-th edge; the sequencer acts on the edge after.
            if (m_n > 0 && m_n % D == 0) begin
                case (m_phase)
                    0: if (m_el + 1 >= MGD && m_d2) begin m_phase <= 1; m_el <= 0; end
                       else if (m_el < MGD) m_el <= m_el + 1;
                    1: if (m_el + 1 == MYD) begin m_phase <= 2; m_el <= 0; end
                       else m_el <= m_el + 1;
                    2: if (m_el + 1 == CGD || !m_d2) begin m_phase <= 3; m_el <= 0; end
                       else m_el <= m_el + 1;
                    default: if (m_el + 1 == CYD) begin m_phase <= 0; m_el <= 0; end
                       else m_el <= m_el + 1;
                endcase
            end
            m_d2 <= m_d1;
            m_d1 <= c_car;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("model_state", int'(current_state), m_phase);
            chk("model_remain", int'(remain), dur(m_phase) - m_el);
            chk("model_tick", int'(tick), int'(m_n > 0 && m_n % D == 0));
        end
    end

    // ---------------- helpers ----------------
    // Returns at the negedge where tick is high; the next edge applies the decision.
    task automatic wait_tick(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!tick && k < 4 * D) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_tick_seen"}, int'(tick), 1);
    endtask

    task automatic wait_until(input string nm, input int st, input int rem);
        int k;
        k = 0;
        @(negedge clk);
        while (!(int'(current_state) == st && (rem < 0 || int'(remain) == rem)) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_reached"}, int'(current_state), st);
    endtask

    typedef struct {
        logic car;
        int   st;
        int   rem;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        // Full cycle with a car always waiting, one row per elapsed second.
        tbl[0]  = '{1'b1, 0, 4}; tbl[1]  = '{1'b1, 0, 3}; tbl[2]  = '{1'b1, 0, 2};
        tbl[3]  = '{1'b1, 0, 1}; tbl[4]  = '{1'b1, 1, 2}; tbl[5]  = '{1'b1, 1, 1};
        tbl[6]  = '{1'b1, 2, 6}; tbl[7]  = '{1'b1, 2, 5}; tbl[8]  = '{1'b1, 2, 4};
        tbl[9]  = '{1'b1, 2, 3}; tbl[10] = '{1'b1, 2, 2}; tbl[11] = '{1'b1, 2, 1};
        tbl[12] = '{1'b1, 3, 2}; tbl[13] = '{1'b1, 3, 1}; tbl[14] = '{1'b1, 0, 5};

        rst_n = 1'b0;
        c_car = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(current_state), 0);
        chk("rst_remain", int'(remain), MGD);
        chk("rst_tick", int'(tick), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // No traffic for 100 clk: main green, countdown parks at 0.
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            chk("idle_state", int'(current_state), 0);
            chk("idle_remain", int'(remain), ((n - 1) / D >= MGD) ? 0 : MGD - (n - 1) / D);
            chk("idle_tick", int'(tick), int'(n % D == 0));
        end

        // Car present from reset.
        rst_n = 1'b0;
        c_car = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            c_car = tbl[i].car;
            wait_tick($sformatf("tbl%0d", i));
            @(negedge clk);
            chk($sformatf("tbl%0d_state", i), int'(current_state), tbl[i].st);
            chk($sformatf("tbl%0d_remain", i), int'(remain), tbl[i].rem);
        end

        // Country road empties with 4 s of green left.
        wait_until("cg4", 2, 4);
        c_car = 1'b0;
        wait_tick("cg_early");
        @(negedge clk);
        chk("cg_early_state", int'(current_state), 3);
        chk("cg_early_remain", int'(remain), 2);

        // One-clk sensor glitch away from the tick while main green holds 0.
        wait_until("mg0_a", 0, 0);
        wait_tick("glitch_align");
        @(negedge clk);
        c_car = 1'b1;
        @(negedge clk);
        c_car = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_tick("glitch");
            @(negedge clk);
            chk("glitch_state", int'(current_state), 0);
        end

        // Car arrives early enough to be seen at the next tick.
        wait_tick("rise_a_align");
        @(negedge clk);
        @(negedge clk);
        c_car = 1'b1;
        wait_tick("rise_a");
        @(negedge clk);
        chk("rise_a_state", int'(current_state), 1);
        chk("rise_a_remain", int'(remain), MYD);

        // Car arrives too close to the tick: picked up one second later.
        c_car = 1'b0;
        wait_until("mg0_b", 0, 0);
        wait_tick("rise_b_align");
        repeat (3) @(negedge clk);
        c_car = 1'b1;
        wait_tick("rise_b_late");
        @(negedge clk);
        chk("rise_b_late_state", int'(current_state), 0);
        wait_tick("rise_b");
        @(negedge clk);
        chk("rise_b_state", int'(current_state), 1);

        // Asynchronous reset in the middle of country yellow.
        wait_until("cy", 3, -1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(current_state), 0);
        chk("arst_remain", int'(remain), MGD);
        chk("arst_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 3 * D && first == 0; k++) begin
            @(posedge clk);
            #1;
            if (tick) first = k;
        end
        chk("arst_first_tick", first, D);

        // Random sensor traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) c_car = ~c_car;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tra_state_ctrl.md
# tra_state_ctrl

Sequencer for the highway/country-road intersection: generates the 2-bit `current_state` code that the light-driver block decodes into RYG outputs, so it sits at the opposite end of that interface. It holds the main road green by default, yields to the country road when the vehicle sensor reports a waiting car, and times each phase from a 1-second tick derived from `clk`. A remaining-seconds count is exported for the countdown display.

## Interface

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1 s tick (≥2)
- M_GREEN_MIN, 30, minimum main-green seconds (1..255)
- M_YELLOW, 3, main-yellow seconds (1..255)
- C_GREEN_MAX, 20, maximum country-green seconds (1..255)
- C_YELLOW, 3, country-yellow seconds (1..255)

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- c_car  in  1  country-road vehicle sensor, asynchronous level, 1 = car waiting
- current_state  out  2  0 = MG (main G / country R), 1 = MY (main Y / country R), 2 = CG (main R / country G), 3 = CY (main R / country Y)
- remain  out  8  seconds left in current phase, unsigned
- tick  out  1  one-clk pulse per second

## Operation

- `c_car` passes through a 2-flop synchronizer → `car_s`; FSM samples `car_s` only on cycles where `tick`=1.
- Prescaler counts 0..TICK_DIV-1 and wraps; `tick`=1 on the wrap cycle.
- On every state entry, `remain` loads that state's duration (MG: M_GREEN_MIN, MY: M_YELLOW, CG: C_GREEN_MAX, CY: C_YELLOW).
- All decisions occur only on tick cycles; with no tick, state and `remain` hold.
- MG: remain>1 → decrement. remain==1 → if car_s, go MY; otherwise remain←0. remain==0 → if car_s, go MY; otherwise hold 0 (the main road stays green indefinitely).
- MY: remain==1 → go CG; otherwise decrement.
- CG: remain==1 or car_s==0 → go CY; otherwise decrement. This gives early exit when the country road empties and forced exit at C_GREEN_MAX.
- CY: remain==1 → go MG; otherwise decrement.
- The 2-bit encoding is fixed; no illegal states exist. Arithmetic is 8-bit unsigned and never underflows, because decrement happens only from values ≥2.

## Timing

- Reset (async assert, sync release): current_state=0 (MG), remain=M_GREEN_MIN, tick=0, prescaler=0, synchronizer flops=0.
- First tick occurs TICK_DIV cycles after reset release.
- State/remain update takes effect the clk edge after the tick cycle (registered outputs, no combinational path from inputs).
- `c_car` → `car_s` latency is 2 clk; a sensor change less than 2 clk before a tick is seen at the next tick.
- MY and CY last exactly M_YELLOW / C_YELLOW ticks. CG lasts 1..C_GREEN_MAX ticks. MG lasts ≥M_GREEN_MIN ticks, and exactly M_GREEN_MIN if car_s=1 at the M_GREEN_MIN-th tick.
- A car arriving while in MY/CG/CY does not shorten or extend those phases beyond the rules above.
- Reset mid-phase returns immediately to MG with a full minimum.

## Structure

- Shared package `tra_pkg`: state localparams ST_MG=2'd0, ST_MY=2'd1, ST_CG=2'd2, ST_CY=2'd3, used by this block and the light driver.
- Sub-module `tick_gen` (prescaler with parameter TICK_DIV, outputs tick). The FSM, remain counter, and synchronizer live in the top.

## Test plan

(Bench uses TICK_DIV=4, M_GREEN_MIN=5, M_YELLOW=2, C_GREEN_MAX=6, C_YELLOW=2.)
- Reset, c_car=0 for 100 clk → state 0 throughout; remain steps 5,4,3,2,1,0 then holds 0; tick every 4 clk.
- c_car=1 from reset → MG 5 ticks, MY 2 ticks, CG 6 ticks (forced exit), CY 2 ticks, MG with remain=5.
- In CG with remain=4, drop c_car → at the next tick the state becomes 3 and remain becomes 2.
- c_car raised while MG holds remain=0 → MY entered at the first tick ≥2 clk after the rise; a rise 1 clk before a tick → MY entered one tick later.
- Assert rst_n=0 mid-CY (asynchronously, between edges) → outputs become state 0, remain 5, tick 0 immediately; after release, the first tick comes 4 clk later.
- c_car 1-clk glitch not aligned to a tick → no state change.
